fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 86 ++++++++
 tb/tb_fetch_stage.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: pre-IF address generation, IF register, and a one-entry
// instruction buffer that holds SRAM read data while decode is stalled.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_allowin,
    output logic        if_to_id_valid,
    output logic [63:0] if_reg,
    input  logic [32:0] branch_reg,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    logic        r_pre_valid;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic        r_buf_valid;
    logic [31:0] r_inst_buf;
    logic        r_br_done;

    logic        w_br_taken;
    logic [31:0] w_br_target;
    logic        w_br_fire;
    logic        w_if_allowin;
    logic        w_issue;
    logic [31:0] w_nextpc;
    logic        w_if_to_id_valid;

    assign w_br_taken  = branch_reg[32];
    assign w_br_target = branch_reg[31:0];

    // br_done masks a branch that decode keeps asserting while stalled, so it redirects once.
    assign w_br_fire        = w_br_taken & ~r_br_done;
    assign w_if_allowin     = ~r_if_valid | id_allowin | w_br_fire;
    assign w_issue          = r_pre_valid & w_if_allowin;
    assign w_nextpc         = w_br_fire ? w_br_target : r_if_pc + 32'd4;
    assign w_if_to_id_valid = r_if_valid & ~w_br_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre_valid <= 1'b0;
            r_if_valid  <= 1'b0;
            r_if_pc     <= RESET_PC - 32'd4;
            r_buf_valid <= 1'b0;
            r_inst_buf  <= 32'h0;
            r_br_done   <= 1'b0;
        end else begin
            r_pre_valid <= 1'b1;

            if (id_allowin)
                r_br_done <= 1'b0;
            else if (w_br_fire)
                r_br_done <= 1'b1;

            if (w_issue) begin
                r_if_pc    <= w_nextpc;
                r_if_valid <= 1'b1;
            end else if (w_br_fire) begin
                r_if_valid <= 1'b0;
            end else if (r_if_valid & id_allowin) begin
                r_if_valid <= 1'b0;
            end

            // SRAM data is only valid the cycle after the request; capture it if decode did not take it.
            if (w_issue | w_br_fire) begin
                r_buf_valid <= 1'b0;
            end else if (r_if_valid & ~r_buf_valid & ~(w_if_to_id_valid & id_allowin)) begin
                r_buf_valid <= 1'b1;
                r_inst_buf  <= inst_sram_rdata;
            end
        end
    end

    assign if_to_id_valid  = w_if_to_id_valid;
    assign if_reg          = {(r_buf_valid ? r_inst_buf : inst_sram_rdata), r_if_pc};
    assign inst_sram_en    = w_issue;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_addr  = w_nextpc;
    assign inst_sram_wdata = 32'h0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: SRAM model returns ~addr one cycle after a request
// and garbage otherwise, so buffered instructions are distinguishable.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_allowin;
    logic        if_to_id_valid;
    logic [63:0] if_reg;
    logic [32:0] branch_reg;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    int n_cmp = 0;
    int n_err = 0;

    fetch_stage #(.RESET_PC(32'h1c000000)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_allowin      (id_allowin),
        .if_to_id_valid  (if_to_id_valid),
        .if_reg          (if_reg),
        .branch_reg      (branch_reg),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        inst_sram_rdata <= inst_sram_en ? ~inst_sram_addr : 32'hBAD0BAD0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge, apply inputs, let combinational outputs settle.
    task automatic cyc(input logic rst, input logic alw, input logic [32:0] br);
        @(negedge clk);
        reset      = rst;
        id_allowin = alw;
        branch_reg = br;
        #1;
    endtask

    task automatic chk_fetch(input string tag, input logic en, input logic [31:0] addr);
        chk({tag, ".en"}, {63'd0, inst_sram_en}, {63'd0, en});
        if (en) chk({tag, ".addr"}, {32'd0, inst_sram_addr}, {32'd0, addr});
    endtask

    task automatic chk_if(input string tag, input logic vld, input logic [31:0] inst, input logic [31:0] pc);
        chk({tag, ".vld"}, {63'd0, if_to_id_valid}, {63'd0, vld});
        if (vld) chk({tag, ".if_reg"}, if_reg, {inst, pc});
    endtask

    initial begin
        reset = 1'b1; id_allowin = 1'b1; branch_reg = 33'd0;
        repeat (3) cyc(1'b1, 1'b1, 33'd0);
        chk_fetch("rst", 1'b0, 32'h0);
        chk("rst.vld", {63'd0, if_to_id_valid}, 64'd0);
        chk("rst.pc", {32'd0, if_reg[31:0]}, 64'h1bfffffc);
        chk("rst.we", {60'd0, inst_sram_we}, 64'd0);
        chk("rst.wdata", {32'd0, inst_sram_wdata}, 64'd0);

        // Release: first reset-low cycle still has pre_valid=0.
        cyc(1'b0, 1'b1, 33'd0);
        chk_fetch("rel0", 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 33'd0);
        chk_fetch("c1", 1'b1, 32'h1c000000);
        chk_if("c1", 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b1, 33'd0);
        chk_if("c2", 1'b1, 32'he3ffffff, 32'h1c000000);
        chk_fetch("c2", 1'b1, 32'h1c000004);
        cyc(1'b0, 1'b1, 33'd0);
        chk_if("c3", 1'b1, 32'he3fffffb, 32'h1c000004);
        chk_fetch("c3", 1'b1, 32'h1c000008);

        // Decode stall for three cycles with pc 0x1c000008 in IF.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 33'd0);
            chk_if($sformatf("stall%0d", i), 1'b1, 32'he3fffff7, 32'h1c000008);
            chk_fetch($sformatf("stall%0d", i), 1'b0, 32'h0);
        end
        cyc(1'b0, 1'b1, 33'd0);
        chk_if("resume", 1'b1, 32'he3fffff7, 32'h1c000008);
        chk_fetch("resume", 1'b1, 32'h1c00000c);
        cyc(1'b0, 1'b1, 33'd0);
        chk_if("c8", 1'b1, 32'he3fffff3, 32'h1c00000c);
        chk_fetch("c8", 1'b1, 32'h1c000010);

        // Single-cycle taken branch with decode accepting.
        cyc(1'b0, 1'b1, {1'b1, 32'h1c000100});
        chk_if("br1", 1'b0, 32'h0, 32'h0);
        chk_fetch("br1", 1'b1, 32'h1c000100);
        cyc(1'b0, 1'b1, 33'd0);
        chk_if("br1t", 1'b1, 32'he3fffeff, 32'h1c000100);
        chk_fetch("br1t", 1'b1, 32'h1c000104);

        // Branch held three cycles while decode is stalled.
        cyc(1'b0, 1'b0, {1'b1, 32'h1c000200});
        chk_if("brh0", 1'b0, 32'h0, 32'h0);
        chk_fetch("brh0", 1'b1, 32'h1c000200);
        cyc(1'b0, 1'b0, {1'b1, 32'h1c000200});
        chk_if("brh1", 1'b1, 32'he3fffdff, 32'h1c000200);
        chk_fetch("brh1", 1'b0, 32'h0);
        cyc(1'b0, 1'b0, {1'b1, 32'h1c000200});
        chk_if("brh2", 1'b1, 32'he3fffdff, 32'h1c000200);
        chk_fetch("brh2", 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 33'd0);
        chk_if("brh3", 1'b1, 32'he3fffdff, 32'h1c000200);
        chk_fetch("brh3", 1'b1, 32'h1c000204);
        cyc(1'b0, 1'b1, 33'd0);
        chk_if("brh4", 1'b1, 32'he3fffdfb, 32'h1c000204);
        chk_fetch("brh4", 1'b1, 32'h1c000208);

        // Unaligned jirl target passes through untouched.
        cyc(1'b0, 1'b1, {1'b1, 32'h1c000102});
        chk_fetch("jirl", 1'b1, 32'h1c000102);
        chk_if("jirl", 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b1, 33'd0);
        chk_if("jirlt", 1'b1, 32'he3fffefd, 32'h1c000102);
        chk_fetch("jirlt", 1'b1, 32'h1c000106);

        // Build buf_valid=1 and br_done=1, then reset.
        cyc(1'b0, 1'b0, {1'b1, 32'h1c000300});
        chk_fetch("pre_rst0", 1'b1, 32'h1c000300);
        cyc(1'b0, 1'b0, {1'b1, 32'h1c000300});
        chk_fetch("pre_rst1", 1'b0, 32'h0);
        cyc(1'b0, 1'b0, {1'b1, 32'h1c000300});
        chk_if("pre_rst2", 1'b1, 32'he3fffcff, 32'h1c000300);
        cyc(1'b1, 1'b0, {1'b1, 32'h1c000300});
        cyc(1'b1, 1'b0, {1'b1, 32'h1c000300});
        chk_fetch("rst2", 1'b0, 32'h0);
        chk("rst2.vld", {63'd0, if_to_id_valid}, 64'd0);
        chk("rst2.pc", {32'd0, if_reg[31:0]}, 64'h1bfffffc);
        cyc(1'b0, 1'b1, 33'd0);
        chk_fetch("rel2", 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 33'd0);
        chk_fetch("restart", 1'b1, 32'h1c000000);
        cyc(1'b0, 1'b1, 33'd0);
        chk_if("restart", 1'b1, 32'he3ffffff, 32'h1c000000);
        chk_fetch("restart1", 1'b1, 32'h1c000004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
